// File: rtl/example_sweep_ctrl.sv
// example_sweep_ctrl: drives every input vector of the 6-input "example" unit,
// waits a settle window per vector, samples Y and accumulates the unit's truth
// table and ones count behind a start/done handshake.
// Optional feature macro: SWEEP_SIG_EN adds an 8-bit MISR over the sampled Y
// stream and the sig_out port.
module example_sweep_ctrl #(
  parameter int NIN    = 6,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                y_in,
  output logic [NIN-1:0]      vec_out,
  output logic                busy,
  output logic                done,
  output logic [NIN:0]        ones_cnt,
`ifdef SWEEP_SIG_EN
  output logic [7:0]          sig_out,
`endif
  output logic [2**NIN-1:0]   table_out
);

  localparam logic [3:0]     SETTLE_C = 4'(SETTLE);
  localparam logic [NIN-1:0] LAST_VEC = {NIN{1'b1}};
  localparam logic [NIN-1:0] VEC_ONE  = {{(NIN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          hold_r, hold_s;
  logic [NIN-1:0]      vec_s;
  logic                busy_s;
  logic                done_s;
  logic [NIN:0]        ones_s;
  logic [2**NIN-1:0]   table_s;
`ifdef SWEEP_SIG_EN
  logic [7:0]          sig_r, sig_s;

  // One MISR step: shift left, fold the feedback polynomial, inject the new Y bit.
  function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic y);
    misr_step = {sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {7'b0000000, y};
  endfunction

  assign sig_out = sig_r;
`endif

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    vec_s   = vec_out;
    ones_s  = ones_cnt;
    table_s = table_out;
    busy_s  = 1'b0;
    done_s  = 1'b0;
`ifdef SWEEP_SIG_EN
    sig_s   = sig_r;
`endif
    case (state_r)
      ST_IDLE: begin
        vec_s = {NIN{1'b0}};
        if (start && !abort) begin
          state_s = ST_DRIVE;
          busy_s  = 1'b1;
          hold_s  = 4'd0;
          ones_s  = {(NIN+1){1'b0}};
          table_s = {(2**NIN){1'b0}};
`ifdef SWEEP_SIG_EN
          sig_s   = 8'h00;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          // Abort wins over the sample edge; partial results stay visible.
          state_s = ST_IDLE;
          vec_s   = {NIN{1'b0}};
          hold_s  = 4'd0;
        end else if (hold_r == SETTLE_C) begin
          table_s[vec_out] = y_in;
          ones_s = ones_cnt + {{NIN{1'b0}}, y_in};
`ifdef SWEEP_SIG_EN
          sig_s  = misr_step(sig_r, y_in);
`endif
          hold_s = 4'd0;
          vec_s  = vec_out + VEC_ONE;
          if (vec_out == LAST_VEC) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            busy_s  = 1'b1;
          end
        end else begin
          hold_s = hold_r + 4'd1;
          busy_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        vec_s   = {NIN{1'b0}};
      end
      default: begin
        state_s = ST_IDLE;
        vec_s   = {NIN{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      hold_r    <= 4'd0;
      vec_out   <= {NIN{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      ones_cnt  <= {(NIN+1){1'b0}};
      table_out <= {(2**NIN){1'b0}};
`ifdef SWEEP_SIG_EN
      sig_r     <= 8'h00;
`endif
    end else begin
      state_r   <= state_s;
      hold_r    <= hold_s;
      vec_out   <= vec_s;
      busy      <= busy_s;
      done      <= done_s;
      ones_cnt  <= ones_s;
      table_out <= table_s;
`ifdef SWEEP_SIG_EN
      sig_r     <= sig_s;
`endif
    end
  end

endmodule

// File: tb/tb_example_sweep_ctrl.sv
// Self-checking bench for example_sweep_ctrl (NIN=6, SETTLE=1).
// The modelled unit output y_in is chosen by 'mode'; expected sweep results
// are queued when a sweep is launched and compared when done pulses.
module tb_example_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        y_in;
  logic [5:0]  vec_out;
  logic        busy;
  logic        done;
  logic [6:0]  ones_cnt;
  logic [63:0] table_out;
`ifdef SWEEP_SIG_EN
  logic [7:0]  sig_out;
`endif

  int mode = 1;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] tbl;
    logic [6:0]  ones;
    logic [7:0]  sig;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  example_sweep_ctrl #(.NIN(6), .SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .y_in      (y_in),
    .vec_out   (vec_out),
    .busy      (busy),
    .done      (done),
    .ones_cnt  (ones_cnt),
`ifdef SWEEP_SIG_EN
    .sig_out   (sig_out),
`endif
    .table_out (table_out)
  );

  // Behaviour of the combinational unit under test for each mode.
  function automatic logic unit_y(input int m, input logic [5:0] v);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return v[0];
      3:       return v[5] & v[0];
      default: return 1'b0;
    endcase
  endfunction

  assign y_in = unit_y(mode, vec_out);

  function automatic logic [7:0] misr_ref(input int m);
    logic [7:0] s;
    s = 8'h00;
    for (int v = 0; v < 64; v++) begin
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, unit_y(m, 6'(v))};
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int m);
    exp_t e;
    e.tbl  = 64'd0;
    e.ones = 7'd0;
    for (int v = 0; v < 64; v++) begin
      e.tbl[v] = unit_y(m, 6'(v));
      e.ones   = e.ones + {6'd0, unit_y(m, 6'(v))};
    end
    e.sig = misr_ref(m);
    exp_q.push_back(e);
  endtask

  // Launch a full sweep from a negedge in IDLE; optionally poke start mid-sweep.
  task automatic run_sweep(input int m, input bit poke);
    exp_t e;
    int cyc;
    int busy_cnt;
    mode = m;
    push_expected(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    chk("clear_ones", 64'(ones_cnt), 64'd0);
    chk("clear_table", table_out, 64'd0);
    chk("first_vec", 64'(vec_out), 64'd0);
    while (!done && cyc < 400) begin
      if (busy) busy_cnt++;
      start = (poke && cyc == 50) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_latency", 64'(cyc), 64'd129);
    chk("busy_cycles", 64'(busy_cnt), 64'd128);
    chk("busy_at_done", 64'(busy), 64'd0);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk("table", table_out, e.tbl);
      chk("ones", 64'(ones_cnt), 64'(e.ones));
`ifdef SWEEP_SIG_EN
      chk("sig", 64'(sig_out), 64'(e.sig));
`endif
    end
    @(negedge clk);
    chk("done_width", 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    bit saw_done;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vec", 64'(vec_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ones", 64'(ones_cnt), 64'd0);
    chk("rst_table", table_out, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a sweep.
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_vec", 64'(vec_out), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ones", 64'(ones_cnt), 64'd0);
    chk("midrst_table", table_out, 64'd0);
    repeat (3) @(negedge clk);
    chk("midrst_idle", 64'(busy), 64'd0);

    // Full sweeps, back to back, with a stray start mid-sweep in the second.
    run_sweep(1, 1'b0);
    chk("ones_all", 64'(ones_cnt), 64'd64);
    chk("table_all", table_out, 64'hFFFF_FFFF_FFFF_FFFF);
    run_sweep(2, 1'b1);
    chk("table_f", table_out, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("ones_f", 64'(ones_cnt), 64'd32);
    run_sweep(3, 1'b0);
    chk("table_af", table_out, 64'hAAAA_AAAA_0000_0000);
    chk("ones_af", 64'(ones_cnt), 64'd16);

    // start together with abort in IDLE is not accepted.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("start_abort_idle", 64'(busy), 64'd0);
    chk("start_abort_keep", table_out, 64'hAAAA_AAAA_0000_0000);

    // Abort when vector 10 is being driven.
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec_out != 6'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec10", 64'(vec_out), 64'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_vec", 64'(vec_out), 64'd0);
    saw_done = done;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    chk("abort_table", table_out, 64'h0000_0000_0000_03FF);
    chk("abort_ones", 64'(ones_cnt), 64'd10);

`ifdef SWEEP_SIG_EN
    run_sweep(0, 1'b0);
    chk("sig_zero", 64'(sig_out), 64'd0);
    run_sweep(2, 1'b0);
    run_sweep(2, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
